// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the chunked adder/subtractor:
//   state_t       - controller states (IDLE / RUN / DONE)
//   op_t          - operation encoding (OP_ADD = 0, OP_SUB = 1)
//   calc_nchunk   - number of CHUNK-bit slices in a WIDTH-bit word
//   calc_cnt_w    - width of the slice counter ($clog2(NCHUNK), at least 1)
// -----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   // Guarded against CHUNK = 0 so that the legality check in the top level
   // reports the problem instead of elaboration dividing by zero here.
   function automatic int calc_nchunk(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   function automatic int calc_cnt_w(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Ports:
//   a, b   - CHUNK-bit addends
//   cin    - carry into bit 0
//   sum    - CHUNK-bit sum
//   cout   - carry out of bit CHUNK-1
//   c_msb  - carry into bit CHUNK-1 (used for signed-overflow detection)
// -----------------------------------------------------------------------------
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder, the cell the chunk adder ripples through.
// Ports:
//   a, b, cin  - addend bits and carry in
//   sum, cout  - sum bit and carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_addsub.sv
// -----------------------------------------------------------------------------
// chunked_addsub
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// processed CHUNK bits per clock through a single chunk_adder, with the
// inter-chunk carry held in a register. Latency is NCHUNK+1 cycles from
// accept to the done cycle; a new operation may be accepted in the done cycle.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request, sampled in IDLE and DONE only
//   sub         - 0 = a+b, 1 = a-b (latched with start)
//   a, b        - operands (latched with start)
//   busy        - high while chunks are being processed (RUN)
//   done        - one-cycle pulse when result/flags are updated
//   result      - sum/difference, held until the next done
//   carry_out   - carry out of the MSB (subtraction: 1 = no borrow)
//   overflow    - signed overflow
//   zero        - result == 0 (after any clamping)
//
// Build option:
//   ADDSUB_SATURATE_EN - clamp result to the most positive / most negative
//                        value on signed overflow; flags stay raw.
// -----------------------------------------------------------------------------
module chunked_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int               NCHUNK     = calc_nchunk(WIDTH, CHUNK);
   localparam int               CNT_W      = calc_cnt_w(NCHUNK);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_addsub: CHUNK must be in 1..WIDTH and divide WIDTH");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, partial;

   logic             accept, run, last;
   logic [31:0]      sh;
   logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
   logic             chunk_cout, chunk_c_msb;
   logic [WIDTH-1:0] full_sum, res_nxt;
   logic             ovf_nxt;

`ifdef ADDSUB_SATURATE_EN
   // On signed overflow both operands share a sign; A's sign picks the clamp.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             ovf,
                                                 input logic             a_msb);
      if (!ovf)
         return raw;
      return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   assign accept = start && (state == IDLE || state == DONE);
   assign run    = (state == RUN);
   assign last   = run && (cnt == LAST);

   // Slice selection by shifting keeps every index expression width-exact.
   assign sh      = 32'(cnt) * 32'(CHUNK);
   assign chunk_a = CHUNK'(a_q >> sh);
   assign chunk_b = CHUNK'(b_q >> sh);

   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a     (chunk_a),
      .b     (chunk_b),
      .cin   (carry_q),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_msb (chunk_c_msb)
   );

   // partial with the current slice merged in; on the last chunk this is the
   // complete wrapped result.
   assign full_sum = (partial & ~(CHUNK_MASK << sh)) | (WIDTH'(chunk_sum) << sh);
   assign ovf_nxt  = chunk_cout ^ chunk_c_msb;

`ifdef ADDSUB_SATURATE_EN
   assign res_nxt = saturate(full_sum, ovf_nxt, a_q[WIDTH-1]);
`else
   assign res_nxt = full_sum;
`endif

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- output logic ----
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      busy = (state == RUN);
      done = (state == DONE);
   end

   // ---- operand and partial-sum registers (data, no reset) ----
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= a;
         b_q <= (op_t'(sub) == OP_SUB) ? ~b : b;
      end
      if (run)
         partial <= full_sum;
   end

   // ---- chunk counter, carry and output registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         carry_q   <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (accept) begin
         cnt     <= '0;
         carry_q <= sub;  // +1 of the two's-complement negate for subtraction
      end else if (run) begin
         carry_q <= chunk_cout;
         if (last) begin
            cnt       <= '0;
            result    <= res_nxt;
            carry_out <= chunk_cout;
            overflow  <= ovf_nxt;
            zero      <= (res_nxt == '0);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_chunked_addsub.sv
// -----------------------------------------------------------------------------
// tb_chunked_addsub
// Directed bench for chunked_addsub. Three instances share clk/rst_n/a/b/sub:
//   index 0: CHUNK = 8  (NCHUNK = 4)
//   index 1: CHUNK = 1  (NCHUNK = 32)
//   index 2: CHUNK = 32 (NCHUNK = 1)
// Expected values are hand-computed; ADDSUB_SATURATE_EN selects the clamped
// expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chunked_addsub;

   localparam int WIDTH = 32;
`ifdef ADDSUB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sub;
   logic [WIDTH-1:0] a, b;
   logic [2:0]       start_v, busy_v, done_v, carry_v, ovf_v, zero_v;
   logic [WIDTH-1:0] result_v [3];

   int nchunk [3] = '{4, 32, 1};
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   chunked_addsub #(.WIDTH(WIDTH), .CHUNK(8)) u_c8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]),
      .carry_out(carry_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

   chunked_addsub #(.WIDTH(WIDTH), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]),
      .carry_out(carry_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

   chunked_addsub #(.WIDTH(WIDTH), .CHUNK(32)) u_c32 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[2]), .done(done_v[2]), .result(result_v[2]),
      .carry_out(carry_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one operation on instance d and check latency, result and flags.
   task automatic run_op(input int d, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input string tag,
                         input logic [31:0] e_res, input logic e_c,
                         input logic e_o, input logic e_z);
      int n;
      bit seen;
      @(negedge clk);
      a = x; b = y; sub = s; start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      chk({tag, "_busy_run"}, 32'(busy_v[d]), 32'd1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done_v[d]) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, 32'(n + 1), 32'(nchunk[d] + 1));
      chk({tag, "_result"}, result_v[d], e_res);
      chk({tag, "_carry"}, 32'(carry_v[d]), 32'(e_c));
      chk({tag, "_ovf"}, 32'(ovf_v[d]), 32'(e_o));
      chk({tag, "_zero"}, 32'(zero_v[d]), 32'(e_z));
      chk({tag, "_busy_done"}, 32'(busy_v[d]), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(done_v[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] dv;
      logic [31:0] r1, r2, rmid;
      string       nm [3] = '{"c8", "c1", "c32"};

      rst_n = 1'b0; start_v = '0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk({nm[d], "_rst_busy"}, 32'(busy_v[d]), 32'd0);
         chk({nm[d], "_rst_done"}, 32'(done_v[d]), 32'd0);
         chk({nm[d], "_rst_result"}, result_v[d], 32'd0);
         chk({nm[d], "_rst_carry"}, 32'(carry_v[d]), 32'd0);
         chk({nm[d], "_rst_ovf"}, 32'(ovf_v[d]), 32'd0);
         chk({nm[d], "_rst_zero"}, 32'(zero_v[d]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int d = 0; d < 3; d++) begin
         run_op(d, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, {nm[d], "_add_povf"},
                SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
         run_op(d, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {nm[d], "_add_wrap"},
                32'h0000_0000, 1'b1, 1'b0, 1'b1);
         run_op(d, 1'b1, 32'd5, 32'd7, {nm[d], "_sub_neg"},
                32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
         run_op(d, 1'b1, 32'h8000_0000, 32'h0000_0001, {nm[d], "_sub_novf"},
                SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      end

      // Back-to-back on the CHUNK = 8 instance with start held high.
      @(negedge clk);
      a = 32'd1; b = 32'd2; sub = 1'b0; start_v[0] = 1'b1;
      @(posedge clk); #1;
      a = 32'd100; b = 32'd200;  // latched by the DONE-cycle accept
      dv = '0; r1 = '0; r2 = '0; rmid = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         dv[k] = done_v[0];
         if (k == 4) r1 = result_v[0];
         if (k == 6) begin
            rmid = result_v[0];
            a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1'b1;  // must be ignored
         end
         if (k == 7) start_v[0] = 1'b0;
         if (k == 9) r2 = result_v[0];
      end
      sub = 1'b0;
      chk("b2b_done_pattern", 32'(dv), 32'h0000_0210);
      chk("b2b_result1", r1, 32'd3);
      chk("b2b_result_hold", rmid, 32'd3);
      chk("b2b_result2", r2, 32'd300);
      chk("b2b_idle_busy", 32'(busy_v[0]), 32'd0);

      // Reset in the second RUN cycle aborts the operation.
      run_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "pre_rst",
             32'h0000_0000, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      a = 32'h7FFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_run_done", 32'(done_v[0]), 32'd0);
      chk("rst_run_result", result_v[0], 32'd0);
      chk("rst_run_carry", 32'(carry_v[0]), 32'd0);
      chk("rst_run_ovf", 32'(ovf_v[0]), 32'd0);
      chk("rst_run_zero", 32'(zero_v[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 1'b0, 32'd3, 32'd4, "post_rst", 32'd7, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
